// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset CPU: opcodes, FSM states,
// datapath mux/mode selects and the decoded instruction-class vector.
package mips_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned FUNCT_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
   localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
   localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXE    = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'd0,
      EXT_SIGN = 2'd1,
      EXT_LUI  = 2'd2
   } ext_op_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_OR  = 3'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      RD_RT = 2'd0,
      RD_RD = 2'd1,
      RD_RA = 2'd2
   } reg_dst_e;

   typedef enum logic [1:0] {
      M2R_ALU = 2'd0,
      M2R_DM  = 2'd1,
      M2R_PC4 = 2'd2
   } mem_to_reg_e;

   typedef enum logic [1:0] {
      NPC_PC4  = 2'd0,
      NPC_BEQ  = 2'd1,
      NPC_JUMP = 2'd2,
      NPC_REG  = 2'd3
   } npc_op_e;

   // One-hot instruction class; all-zero means an unsupported encoding.
   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
   } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode into a one-hot instruction class plus an
// illegal flag for anything outside the supported subset.
module mc_decode
   import mips_pkg::*;
(
   input  logic [OP_W-1:0]    op_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output instr_class_t       cls_c_o,
   output logic               illegal_c_o
);

   always_comb begin
      cls_c_o = '0;
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADDU: cls_c_o.addu = 1'b1;
               FN_SUBU: cls_c_o.subu = 1'b1;
               FN_JR:   cls_c_o.jr   = 1'b1;
               default: ;
            endcase
         end
         OP_ORI:  cls_c_o.ori = 1'b1;
         OP_LUI:  cls_c_o.lui = 1'b1;
         OP_LW:   cls_c_o.lw  = 1'b1;
         OP_SW:   cls_c_o.sw  = 1'b1;
         OP_BEQ:  cls_c_o.beq = 1'b1;
         OP_J:    cls_c_o.j   = 1'b1;
         OP_JAL:  cls_c_o.jal = 1'b1;
         default: ;
      endcase
   end

   assign illegal_c_o = (cls_c_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath enable and select, and counts retired instructions.
module mc_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               zero,
   input  logic               dm_ready,
   output logic               PCWr,
   output logic               IRWr,
   output logic               RegWr,
   output logic               MemWr,
   output logic               MemRd,
   output logic [1:0]         ExtOP,
   output logic               ALUSrc,
   output logic [2:0]         ALUOp,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         NPCOp,
   output logic [2:0]         state,
   output logic               retire,
   output logic               illegal,
   output logic [CNT_W-1:0]   instr_cnt
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   instr_class_t     cls;
   logic             illegal_enc;

   mc_decode u_decode (
      .op_i        (op),
      .funct_i     (funct),
      .cls_c_o     (cls),
      .illegal_c_o (illegal_enc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = (cls.j | cls.jal | cls.jr | illegal_enc) ? ST_FETCH : ST_EXE;
         ST_EXE: begin
            if (cls.beq)              state_d = ST_FETCH;
            else if (cls.lw | cls.sw) state_d = ST_MEM;
            else                      state_d = ST_WB;
         end
         ST_MEM: begin
            if (!dm_ready)   state_d = ST_MEM;
            else if (cls.lw) state_d = ST_WB;
            else             state_d = ST_FETCH;
         end
         ST_WB:   state_d = ST_FETCH;
         default: state_d = ST_FETCH;
      endcase
   end

   // Outputs are forced low while reset is high, so an access in flight drops at once.
   always_comb begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      RegWr    = 1'b0;
      MemWr    = 1'b0;
      MemRd    = 1'b0;
      ExtOP    = EXT_ZERO;
      ALUSrc   = 1'b0;
      ALUOp    = ALU_ADD;
      RegDst   = RD_RT;
      MemtoReg = M2R_ALU;
      NPCOp    = NPC_PC4;
      retire   = 1'b0;
      illegal  = 1'b0;
      if (!reset) begin
         // ALU/extender setup is held from EXE through MEM and WB.
         if (state_q inside {ST_EXE, ST_MEM, ST_WB}) begin
            if (cls.lui)                        ExtOP = EXT_LUI;
            else if (cls.lw | cls.sw | cls.beq) ExtOP = EXT_SIGN;
            ALUSrc = cls.ori | cls.lui | cls.lw | cls.sw;
            if (cls.ori | cls.lui)        ALUOp = ALU_OR;
            else if (cls.subu | cls.beq)  ALUOp = ALU_SUB;
         end
         case (state_q)
            ST_FETCH: begin
               IRWr = 1'b1;
               PCWr = 1'b1;
            end
            ST_DECODE: begin
               if (cls.j | cls.jal) begin
                  PCWr  = 1'b1;
                  NPCOp = NPC_JUMP;
               end
               if (cls.jal) begin
                  RegWr    = 1'b1;
                  RegDst   = RD_RA;
                  MemtoReg = M2R_PC4;
               end
               if (cls.jr) begin
                  PCWr  = 1'b1;
                  NPCOp = NPC_REG;
               end
               retire  = cls.j | cls.jal | cls.jr;
               illegal = illegal_enc;
            end
            ST_EXE: begin
               if (cls.beq) begin
                  NPCOp  = NPC_BEQ;
                  PCWr   = zero;
                  retire = 1'b1;
               end
            end
            ST_MEM: begin
               MemRd  = cls.lw;
               MemWr  = cls.sw;
               retire = cls.sw & dm_ready;
            end
            ST_WB: begin
               RegWr    = 1'b1;
               RegDst   = (cls.addu | cls.subu) ? RD_RD : RD_RT;
               MemtoReg = cls.lw ? M2R_DM : M2R_ALU;
               retire   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      instr_cnt_d = instr_cnt_q;
      if (retire) instr_cnt_d = instr_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) instr_cnt_q <= '0;
      else       instr_cnt_q <= instr_cnt_d;
   end

   assign state     = state_q;
   assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model derives the per-cycle control
// word from each instruction's state path; outputs are compared every cycle.
module tb_mc_ctrl;

   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       op, funct;
   logic             zero, dm_ready;
   logic             PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, retire, illegal;
   logic [1:0]       ExtOP, RegDst, MemtoReg, NPCOp;
   logic [2:0]       ALUOp, state;
   logic [CNT_W-1:0] instr_cnt;

   typedef struct packed {
      logic [2:0] st;
      logic       pcwr, irwr, regwr, memwr, memrd;
      logic [1:0] ext;
      logic       alusrc;
      logic [2:0] aluop;
      logic [1:0] regdst, m2r, npc;
      logic       retire, illegal;
   } obs_t;

   typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                     K_J, K_JAL, K_ILL_OP, K_ILL_FN} kind_e;

   obs_t             dut_v, exp_cur;
   int               checks = 0;
   int               errors = 0;
   logic             chk_en = 1'b0;
   logic [CNT_W-1:0] cnt_exp;

   mc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .dm_ready(dm_ready),
      .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .MemRd(MemRd),
      .ExtOP(ExtOP), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .NPCOp(NPCOp), .state(state), .retire(retire),
      .illegal(illegal), .instr_cnt(instr_cnt)
   );

   assign dut_v = {state, PCWr, IRWr, RegWr, MemWr, MemRd, ExtOP, ALUSrc, ALUOp,
                   RegDst, MemtoReg, NPCOp, retire, illegal};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [11:0] encode(input kind_e k);
      case (k)
         K_ADDU:   return {6'h00, 6'h21};
         K_SUBU:   return {6'h00, 6'h23};
         K_JR:     return {6'h00, 6'h08};
         K_ORI:    return {6'h0D, 6'h15};
         K_LUI:    return {6'h0F, 6'h00};
         K_LW:     return {6'h23, 6'h04};
         K_SW:     return {6'h2B, 6'h00};
         K_BEQ:    return {6'h04, 6'h21};
         K_J:      return {6'h02, 6'h08};
         K_JAL:    return {6'h03, 6'h00};
         K_ILL_OP: return {6'h3F, 6'h21};
         default:  return {6'h00, 6'h20};
      endcase
   endfunction

   // Expected control word for instruction k while it occupies state st.
   function automatic obs_t model(input kind_e k, input int st, input logic z, input logic last);
      obs_t e;
      e        = '0;
      e.st     = 3'(st);
      e.retire = last;
      if (st == 0) begin
         e.irwr = 1'b1;
         e.pcwr = 1'b1;
      end else if (st == 1) begin
         case (k)
            K_J:   begin e.pcwr = 1'b1; e.npc = 2'd2; end
            K_JAL: begin e.pcwr = 1'b1; e.npc = 2'd2; e.regwr = 1'b1; e.regdst = 2'd2; e.m2r = 2'd2; end
            K_JR:  begin e.pcwr = 1'b1; e.npc = 2'd3; end
            K_ILL_OP, K_ILL_FN: e.illegal = 1'b1;
            default: ;
         endcase
      end else begin
         e.ext    = (k == K_LUI) ? 2'd2 : (k inside {K_LW, K_SW, K_BEQ}) ? 2'd1 : 2'd0;
         e.alusrc = (k inside {K_ORI, K_LUI, K_LW, K_SW});
         e.aluop  = (k inside {K_ORI, K_LUI}) ? 3'd2 : (k inside {K_SUBU, K_BEQ}) ? 3'd1 : 3'd0;
         if (st == 2 && k == K_BEQ) begin
            e.npc  = 2'd1;
            e.pcwr = z;
         end
         if (st == 3) begin
            e.memrd = (k == K_LW);
            e.memwr = (k == K_SW);
         end
         if (st == 4) begin
            e.regwr  = 1'b1;
            e.m2r    = (k == K_LW) ? 2'd1 : 2'd0;
            e.regdst = (k inside {K_ADDU, K_SUBU}) ? 2'd1 : 2'd0;
         end
      end
      return e;
   endfunction

   // Runs one instruction; its state path follows from the instruction class and CPI.
   task automatic run(input kind_e k, input logic z, input int waits, input logic noise,
                      output int ncyc);
      int          path[$];
      int          mem_i;
      logic [11:0] enc;
      bit          ill;
      ill   = (k inside {K_ILL_OP, K_ILL_FN});
      mem_i = 0;
      path  = '{0, 1};
      if (!(k inside {K_J, K_JAL, K_JR}) && !ill) path.push_back(2);
      if (k inside {K_LW, K_SW})
         for (int i = 0; i <= waits; i++) path.push_back(3);
      if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) path.push_back(4);
      enc   = encode(k);
      op    = enc[11:6];
      funct = enc[5:0];
      ncyc  = path.size();
      foreach (path[i]) begin
         zero = z;
         if (path[i] == 3) begin
            dm_ready = (mem_i == waits);
            mem_i++;
         end else begin
            dm_ready = noise;
         end
         exp_cur = model(k, path[i], z, (i == ncyc - 1) && !ill);
         chk_en  = 1'b1;
         @(posedge clk); #1;
         if (exp_cur.retire) cnt_exp = cnt_exp + CNT_W'(1);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ctrl_word", 64'(dut_v), 64'(exp_cur));
         check("instr_cnt", 64'(instr_cnt), 64'(cnt_exp));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset    = 1'b1;
      op       = 6'h03;
      funct    = 6'h00;
      zero     = 1'b1;
      dm_ready = 1'b1;
      cnt_exp  = '0;
      exp_cur  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'(dut_v), 64'd0);
      check("reset_cnt", 64'(instr_cnt), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      run(K_ORI, 1'b0, 0, 1'b1, n);
      check("ori_cycles", 64'(n), 64'd4);
      check("ori_cnt", 64'(instr_cnt), 64'd1);
      run(K_ADDU, 1'b1, 0, 1'b1, n);
      run(K_SUBU, 1'b0, 0, 1'b0, n);
      run(K_JR, 1'b0, 0, 1'b1, n);
      run(K_J, 1'b1, 0, 1'b0, n);
      run(K_LW, 1'b0, 3, 1'b1, n);
      check("lw_cycles", 64'(n), 64'd8);
      check("lw_cnt", 64'(instr_cnt), 64'd6);
      run(K_BEQ, 1'b1, 0, 1'b0, n);
      check("beq_taken_cycles", 64'(n), 64'd3);
      run(K_BEQ, 1'b0, 0, 1'b1, n);
      check("beq_not_taken_cycles", 64'(n), 64'd3);
      run(K_JAL, 1'b0, 0, 1'b0, n);
      check("jal_cycles", 64'(n), 64'd2);
      run(K_ILL_OP, 1'b0, 0, 1'b1, n);
      check("illegal_cycles", 64'(n), 64'd2);
      run(K_ILL_FN, 1'b1, 0, 1'b0, n);
      check("illegal_cnt", 64'(instr_cnt), 64'd9);
      run(K_LUI, 1'b0, 0, 1'b0, n);
      run(K_SW, 1'b1, 0, 1'b1, n);
      run(K_SW, 1'b0, 2, 1'b1, n);
      check("sw_wait_cycles", 64'(n), 64'd6);
      check("total_cnt", 64'(instr_cnt), 64'd12);

      // sw stalled in MEM, then reset asserted between clock edges
      op       = 6'h2B;
      funct    = 6'h00;
      zero     = 1'b0;
      dm_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         exp_cur = model(K_SW, s, 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      exp_cur = model(K_SW, 3, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk_en = 1'b0;
      check("memwr_before_reset", 64'(MemWr), 64'd1);
      reset = 1'b1;
      #1;
      check("memwr_on_reset", 64'(MemWr), 64'd0);
      check("state_on_reset", 64'(state), 64'd0);
      check("cnt_on_reset", 64'(instr_cnt), 64'd0);
      check("outputs_on_reset", 64'(dut_v), 64'd0);
      cnt_exp = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      run(K_ORI, 1'b1, 0, 1'b0, n);
      check("cnt_after_reset", 64'(instr_cnt), 64'd1);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS-subset CPU.
- Sequences fetch/decode/execute/memory/writeback over a shared datapath: PC, IR, GRF, ALU, immediate extender and DM.
- Drives every datapath enable and mux select, including the extender mode ExtOP.
- Waits on a data-memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears state and counter immediately
- op  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0], valid from DECODE onward
- zero  in  1  ALU equality flag, valid in EXE
- dm_ready  in  1  DM completes access this cycle (MEM state only)
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RegWr  out  1  GRF write enable
- MemWr  out  1  DM write strobe
- MemRd  out  1  DM read strobe
- ExtOP  out  2  extender mode: 0 zero-ext, 1 sign-ext, 2 lui (imm<<16)
- ALUSrc  out  1  0 = GRF rt, 1 = extended immediate
- ALUOp  out  3  0 add, 1 sub, 2 or
- RegDst  out  2  0 rt, 1 rd, 2 $31
- MemtoReg  out  2  0 ALU result, 1 DM data, 2 PC+4
- NPCOp  out  2  0 PC+4, 1 beq target, 2 j/jal target, 3 GRF[rs]
- state  out  3  current state, for debug
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Supported instructions: addu, subu, jr (op 0, funct 0x21/0x23/0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Encodings 5-7 go to FETCH next cycle with all enables 0.
- Reset: state=FETCH, instr_cnt=0. While reset is high, all outputs are 0, including the enables, retire and illegal.
- First FETCH occurs on the first edge after reset deasserts.
- Outputs are Moore-decoded from state plus op/funct. Every enable not listed below is 0.
- FETCH: IRWr=1, PCWr=1, NPCOp=0. Next state DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=2.
  - jal: PCWr=1, NPCOp=2, RegWr=1, RegDst=2, MemtoReg=2.
  - jr: PCWr=1, NPCOp=3.
  - For j/jal/jr: retire=1, next state FETCH.
  - Illegal encoding: illegal=1, next state FETCH, no retire (acts as nop).
  - All other instructions: next state EXE.
- EXE: ExtOP is 0 for ori, 1 for lw/sw/beq, 2 for lui; ALUSrc=1 for ori/lui/lw/sw.
  - addu: ALUOp=0, next state WB.
  - subu: ALUOp=1, next state WB.
  - ori/lui: ALUOp=2, next state WB. The datapath zeroes the lui ALU rs operand, so result = extended immediate.
  - lw/sw: ALUOp=0, next state MEM.
  - beq: ALUOp=1, NPCOp=1, PCWr=zero, retire=1, next state FETCH.
- MEM: MemRd=1 for lw; MemWr=1 for sw.
  - Strobes are held and state stays MEM while dm_ready=0; no timeout.
  - dm_ready=1 with sw: retire=1, next state FETCH.
  - dm_ready=1 with lw: next state WB.
- WB: RegWr=1.
  - lw: MemtoReg=1, RegDst=0.
  - R-type: MemtoReg=0, RegDst=1.
  - ori/lui: MemtoReg=0, RegDst=0.
  - retire=1, next state FETCH.
- ExtOP/ALUSrc/ALUOp values are also held in MEM/WB for the same instruction.
- instr_cnt increments on every retire and wraps modulo 2^CNT_W.
- dm_ready outside MEM is ignored.
- Reset mid-MEM drops the strobes immediately (async). The instruction is not retired and the count is not incremented.
- CPI: j/jal/jr 2, beq 3, R/ori/lui 4, sw 4+wait, lw 5+wait.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct constants;
  - state encodings;
  - ExtOP, ALUOp, RegDst, MemtoReg, NPCOp encodings.
- The extender and CPU top reuse the same package.
- One sub-module, mc_decode: combinational op/funct to instruction-class one-hot plus illegal.
- mc_ctrl keeps the state register, output decode and counter.

Test Plan:
- Reset mid-MEM of sw with dm_ready=0 -> MemWr drops same cycle, state=0, instr_cnt=0.
- ori (op 0x0D), dm_ready=1 -> state sequence 0,1,2,4,0. ExtOP=0 and ALUSrc=1 in EXE; RegWr=1 only in WB; instr_cnt=1.
- lw (op 0x23) with dm_ready low for 3 cycles -> MEM held 4 cycles with MemRd=1, ExtOP=1. WB has MemtoReg=1. Total 8 cycles, retire once.
- beq with zero=1, then beq with zero=0 -> PCWr=1 with NPCOp=1 in EXE for the first, PCWr=0 for the second. 3 cycles each.
- jal -> DECODE asserts PCWr, RegWr, RegDst=2, MemtoReg=2, NPCOp=2; back in FETCH next cycle.
- op 0x3F -> illegal pulse in DECODE, no retire, returns to FETCH. lui (op 0x0F) -> ExtOP=2 in EXE.
